// File: rtl/sram_arb.sv
// Two-port (instruction/data) arbiter onto one single-ported SRAM; data wins ties, read data returns two cycles after grant.
// Optional anti-starvation for the instruction port is compiled in with macro SRAM_ARB_STARVE_EN.
module sram_arb #(
  parameter int AW         = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvld,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [3:0]    d_we,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvld,
  output logic [31:0]   d_rdata,
  output logic [AW-1:0] sram_a,
  output logic          sram_e,
  output logic [3:0]    sram_we,
  output logic [31:0]   sram_wd,
  input  logic [31:0]   sram_rd
);

  logic          w_i_gnt;
  logic          w_d_gnt;
  logic          w_force_i;
  logic [AW-1:0] r_sram_a;
  logic          r_sram_e;
  logic [3:0]    r_sram_we;
  logic [31:0]   r_sram_wd;
  logic          r_pend;
  logic          r_own;
  logic          r_i_rvld;
  logic          r_d_rvld;
  logic [31:0]   r_i_rdata;
  logic [31:0]   r_d_rdata;

`ifdef SRAM_ARB_STARVE_EN
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CW-1:0] r_starve_cnt;

  assign w_force_i = i_req && (r_starve_cnt == CW'(STARVE_MAX));

  // Counts consecutive denied instruction cycles; never exceeds STARVE_MAX since that value forces a grant.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)                   r_starve_cnt <= '0;
    else if (!i_req || w_i_gnt) r_starve_cnt <= '0;
    else                        r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`else
  assign w_force_i = 1'b0;
`endif

  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!rstn) begin
      if (w_force_i)  w_i_gnt = 1'b1;
      else if (d_req) w_d_gnt = 1'b1;
      else if (i_req) w_i_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_sram_a  <= '0;
      r_sram_e  <= 1'b0;
      r_sram_we <= 4'b0;
      r_sram_wd <= '0;
      r_pend    <= 1'b0;
      r_own     <= 1'b0;
      r_i_rvld  <= 1'b0;
      r_d_rvld  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_sram_e  <= w_i_gnt | w_d_gnt;
      r_sram_we <= w_d_gnt ? d_we : 4'b0;
      if (w_d_gnt) begin
        r_sram_a  <= d_addr;
        r_sram_wd <= d_wdata;
      end else if (w_i_gnt) begin
        r_sram_a  <= i_addr;
      end
      // pend/own track the access in the SRAM cycle; rvld fires in the cycle sram_rd is valid.
      r_pend   <= w_i_gnt | (w_d_gnt && (d_we == 4'b0));
      r_own    <= w_d_gnt;
      r_i_rvld <= r_pend && !r_own;
      r_d_rvld <= r_pend && r_own;
      if (r_i_rvld) r_i_rdata <= sram_rd;
      if (r_d_rvld) r_d_rdata <= sram_rd;
    end
  end

  assign i_gnt   = w_i_gnt;
  assign d_gnt   = w_d_gnt;
  assign sram_a  = r_sram_a;
  assign sram_e  = r_sram_e;
  assign sram_we = r_sram_we;
  assign sram_wd = r_sram_wd;
  assign i_rvld  = r_i_rvld;
  assign d_rvld  = r_d_rvld;
  // Live data passes straight through; otherwise the last returned word is held.
  assign i_rdata = r_i_rvld ? sram_rd : r_i_rdata;
  assign d_rdata = r_d_rvld ? sram_rd : r_d_rdata;

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: directed stimulus, scoreboard queue of expected read returns checked by a monitor.
module tb_sram_arb;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvld;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_we;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvld;
  logic [31:0]   d_rdata;
  logic [AW-1:0] sram_a;
  logic          sram_e;
  logic [3:0]    sram_we;
  logic [31:0]   sram_wd;
  logic [31:0]   sram_rd;

  sram_arb #(.AW(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvld(i_rvld), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvld(d_rvld), .d_rdata(d_rdata),
    .sram_a(sram_a), .sram_e(sram_e), .sram_we(sram_we), .sram_wd(sram_wd), .sram_rd(sram_rd)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: read data valid the cycle after the enable cycle.
  logic [31:0] mem [0:255];
  logic [31:0] rd_q = '0;
  assign sram_rd = rd_q;
  always @(posedge clk) begin
    if (sram_e) begin
      if (sram_we == 4'b0) rd_q <= mem[sram_a[7:0]];
      else begin
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) mem[sram_a[7:0]][8*b +: 8] <= sram_wd[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        port_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic port_d, input logic [31:0] data);
    exp_t e;
    e.port_d = port_d;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_i_gnt"},   i_gnt,   0);
    chk({tag, "_d_gnt"},   d_gnt,   0);
    chk({tag, "_sram_e"},  sram_e,  0);
    chk({tag, "_sram_we"}, sram_we, 0);
    chk({tag, "_sram_a"},  sram_a,  0);
    chk({tag, "_sram_wd"}, sram_wd, 0);
    chk({tag, "_i_rvld"},  i_rvld,  0);
    chk({tag, "_d_rvld"},  d_rvld,  0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  // Monitor: every rvld must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (i_rvld && d_rvld) begin
      chk("rvld_both", {i_rvld, d_rvld}, 2'b01);
    end else if (i_rvld || d_rvld) begin
      if (exp_q.size() == 0) begin
        chk("rvld_unexpected", {i_rvld, d_rvld}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rvld_port", d_rvld, e.port_d);
        chk("rdata", d_rvld ? d_rdata : i_rdata, e.data);
      end
    end
  end

  initial begin
    logic i_pending;
    logic exp_i;
    for (int a = 0; a < 256; a++) mem[a] = 32'h0;
    mem[8'h05] = 32'h00500093;
    mem[8'h10] = 32'h12345678;
    mem[8'h20] = 32'h11112222;
    mem[8'h21] = 32'h33334444;
    mem[8'h30] = 32'hCAFE0030;
    mem[8'h31] = 32'hBEEF0031;

    rstn = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_addr = '0; d_we = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    i_req = 1'b1; d_req = 1'b1;
    #1 chk_all_zero("reset");
    i_req = 1'b0; d_req = 1'b0;

    // Instruction read alone
    @(negedge clk);
    rstn = 1'b0; i_req = 1'b1; i_addr = 14'h005;
    #1 chk("t1_i_gnt", i_gnt, 1);
    chk("t1_d_gnt", d_gnt, 0);
    push(1'b0, 32'h00500093);
    @(negedge clk);
    i_req = 1'b0;
    chk("t1_sram_a", sram_a, 14'h005);
    chk("t1_sram_e", sram_e, 1);
    chk("t1_sram_we", sram_we, 0);
    repeat (2) @(negedge clk);
    #1 chk("t1_hold_rvld", i_rvld, 0);
    chk("t1_hold_rdata", i_rdata, 32'h00500093);

    // Data partial write, then read back
    @(negedge clk);
    d_req = 1'b1; d_addr = 14'h010; d_we = 4'b0011; d_wdata = 32'hAABBCCDD;
    #1 chk("t2_d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0; d_we = 4'b0;
    chk("t2_sram_we", sram_we, 4'b0011);
    chk("t2_sram_wd", sram_wd, 32'hAABBCCDD);
    chk("t2_sram_a", sram_a, 14'h010);
    @(negedge clk);
    d_req = 1'b1; d_addr = 14'h010;
    #1 chk("t2r_d_gnt", d_gnt, 1);
    push(1'b1, 32'h1234CCDD);
    @(negedge clk);
    d_req = 1'b0;
    repeat (3) @(negedge clk);

    // Simultaneous reads: data first, instruction next cycle
    d_req = 1'b1; d_addr = 14'h020; i_req = 1'b1; i_addr = 14'h021;
    #1 chk("t3_d_gnt", d_gnt, 1);
    chk("t3_i_gnt0", i_gnt, 0);
    push(1'b1, 32'h11112222);
    @(negedge clk);
    d_req = 1'b0;
    #1 chk("t3_i_gnt1", i_gnt, 1);
    chk("t3_sram_a", sram_a, 14'h020);
    push(1'b0, 32'h33334444);
    @(negedge clk);
    i_req = 1'b0;
    repeat (4) @(negedge clk);

    // Sustained contention
    i_pending = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      d_req = 1'b1; d_addr = 14'h030; d_we = 4'b0;
      i_req = i_pending; i_addr = 14'h031;
`ifdef SRAM_ARB_STARVE_EN
      exp_i = (k == 5);
`else
      exp_i = 1'b0;
`endif
      #1 chk("t4_i_gnt", i_gnt, exp_i);
      chk("t4_d_gnt", d_gnt, !exp_i);
      if (exp_i) begin
        push(1'b0, 32'hBEEF0031);
        i_pending = 1'b0;
      end else begin
        push(1'b1, 32'hCAFE0030);
      end
      @(negedge clk);
      i_req = i_pending;
    end
    d_req = 1'b0;
    #1 chk("t4_after_i_gnt", i_gnt, i_pending);
    chk("t4_after_d_gnt", d_gnt, 0);
    if (i_pending) push(1'b0, 32'hBEEF0031);
    @(negedge clk);
    i_req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during a read in flight
    d_req = 1'b1; d_addr = 14'h005;
    #1 chk("t5_d_gnt", d_gnt, 1);
    @(negedge clk);
    d_req = 1'b0; rstn = 1'b1; i_req = 1'b1; i_addr = 14'h005;
    #1 chk_all_zero("t5_rst");
    @(negedge clk);
    #1 chk_all_zero("t5_rst2");
    // Request presented as reset releases is taken at the first edge
    rstn = 1'b0;
    #1 chk("t5_first_i_gnt", i_gnt, 1);
    push(1'b0, 32'h00500093);
    @(negedge clk);
    i_req = 1'b0;
    repeat (5) @(negedge clk);

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
